// File: rtl/mipi_crop_pack.sv
// Crops, optionally decimates by 2, and packs a 24-bit RGB MIPI pixel stream to RGB555 for the arbiter.
// Optional build macro MIPI_CROP_ROUND_EN: round-to-nearest (saturating) instead of truncation.
module mipi_crop_pack #(
  parameter int IN_WIDTH   = 1280,
  parameter int IN_HEIGHT  = 720,
  parameter int CROP_X0    = 0,
  parameter int CROP_Y0    = 0,
  parameter int OUT_WIDTH  = 640,
  parameter int OUT_HEIGHT = 480,
  parameter int DECIM      = 1
) (
  input  logic        iCLK,
  input  logic        iRESETn,
  input  logic [23:0] iDATA,
  input  logic        iDV,
  input  logic        iSTART,
  output logic [14:0] oDATA,
  output logic        oDV,
  output logic        oSTART,
  output logic        oFRAME_ERR,
  output logic        oBUSY,
  output logic [1:0]  dbg_state
);

  localparam int XW  = (IN_WIDTH  > 1) ? $clog2(IN_WIDTH)  : 1;
  localparam int YW  = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
  localparam int XW1 = XW + 1;
  localparam int YW1 = YW + 1;
  localparam logic [XW-1:0] X_LAST = XW'(IN_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IN_HEIGHT - 1);
  localparam logic [XW:0]   X_LO   = XW1'(CROP_X0);
  localparam logic [YW:0]   Y_LO   = YW1'(CROP_Y0);
  localparam logic [XW:0]   X_SPAN = XW1'(OUT_WIDTH * DECIM);
  localparam logic [YW:0]   Y_SPAN = YW1'(OUT_HEIGHT * DECIM);

  if (DECIM != 1 && DECIM != 2) begin : g_bad_decim
    $error("mipi_crop_pack: DECIM must be 1 or 2");
  end
  if (CROP_X0 + OUT_WIDTH * DECIM > IN_WIDTH) begin : g_bad_x
    $error("mipi_crop_pack: horizontal window exceeds IN_WIDTH");
  end
  if (CROP_Y0 + OUT_HEIGHT * DECIM > IN_HEIGHT) begin : g_bad_y
    $error("mipi_crop_pack: vertical window exceeds IN_HEIGHT");
  end

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ACTIVE   = 2'd1,
    DONE     = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [XW-1:0]   x, x_nx, cur_x;
  logic [YW-1:0]   y, y_nx, cur_y;
  logic            long_flag, long_flag_nx;
  logic            err_nx;
  logic            pix_live;
  logic [XW:0]     dx;
  logic [YW:0]     dy;
  logic            keep, first;

  logic            s1_dv, s1_start;
  logic [23:0]     s1_data;

  function automatic logic [4:0] pack5(input logic [7:0] c);
`ifdef MIPI_CROP_ROUND_EN
    logic [8:0] s;
    s = {1'b0, c} + 9'd4;
    return (c >= 8'd252) ? 5'd31 : 5'(s >> 3);
`else
    return 5'(c >> 3);
`endif
  endfunction

  // cur_x/cur_y are the coordinates of the pixel on iDATA this cycle; x/y point at the next one.
  always_comb begin
    state_nx     = state;
    x_nx         = x;
    y_nx         = y;
    long_flag_nx = long_flag;
    err_nx       = 1'b0;
    pix_live     = 1'b0;
    cur_x        = x;
    cur_y        = y;
    if (iDV) begin
      case (state)
        WAIT_SOF: pix_live = iSTART;
        ACTIVE: begin
          pix_live = 1'b1;
          err_nx   = iSTART;
        end
        DONE: begin
          pix_live = iSTART;
          if (!iSTART && !long_flag) begin
            err_nx       = 1'b1;
            long_flag_nx = 1'b1;
          end
        end
        default: state_nx = WAIT_SOF;
      endcase
      if (pix_live) begin
        if (iSTART) begin
          cur_x        = '0;
          cur_y        = '0;
          long_flag_nx = 1'b0;
        end
        state_nx = ACTIVE;
        if (cur_x == X_LAST) begin
          x_nx = '0;
          if (cur_y == Y_LAST) begin
            y_nx     = '0;
            state_nx = DONE;
          end else begin
            y_nx = cur_y + 1'b1;
          end
        end else begin
          x_nx = cur_x + 1'b1;
          y_nx = cur_y;
        end
      end
    end
  end

  // Offsets wrap to large values left/above the window, so one compare covers both bounds.
  always_comb begin
    dx    = {1'b0, cur_x} - X_LO;
    dy    = {1'b0, cur_y} - Y_LO;
    keep  = pix_live && (dx < X_SPAN) && (dy < Y_SPAN) &&
            ((DECIM == 1) || !dx[0]) && ((DECIM == 1) || !dy[0]);
    first = keep && (dx == '0) && (dy == '0);
  end

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      state      <= WAIT_SOF;
      x          <= '0;
      y          <= '0;
      long_flag  <= 1'b0;
      oFRAME_ERR <= 1'b0;
    end else begin
      state      <= state_nx;
      x          <= x_nx;
      y          <= y_nx;
      long_flag  <= long_flag_nx;
      oFRAME_ERR <= err_nx;
    end
  end

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      s1_dv    <= 1'b0;
      s1_start <= 1'b0;
      s1_data  <= '0;
      oDV      <= 1'b0;
      oSTART   <= 1'b0;
      oDATA    <= '0;
    end else begin
      s1_dv    <= keep;
      s1_start <= first;
      if (keep) s1_data <= iDATA;
      oDV      <= s1_dv;
      oSTART   <= s1_start;
      if (s1_dv) oDATA <= {pack5(s1_data[23:16]), pack5(s1_data[15:8]), pack5(s1_data[7:0])};
    end
  end

  assign oBUSY     = (state == ACTIVE);
  assign dbg_state = state;

endmodule

// File: tb/tb_mipi_crop_pack.sv
// Directed scoreboard bench for mipi_crop_pack on an 8x4 frame, window (2,1) 2x2, decimation 2.
module tb_mipi_crop_pack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] i_data = '0;
  logic        i_dv = 1'b0;
  logic        i_start = 1'b0;
  logic [14:0] o_data;
  logic        o_dv, o_start, o_err, o_busy;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Expected output beats {start, data} with the cycle each must appear on.
  logic [15:0] exp_q[$];
  int          exp_cyc_q[$];
  int          err_cyc_q[$];

`ifdef MIPI_CROP_ROUND_EN
  localparam logic [14:0] SPECIAL_EXP = 15'h7E21;
`else
  localparam logic [14:0] SPECIAL_EXP = 15'h7E00;
`endif

  mipi_crop_pack #(
    .IN_WIDTH(8), .IN_HEIGHT(4), .CROP_X0(2), .CROP_Y0(1),
    .OUT_WIDTH(2), .OUT_HEIGHT(2), .DECIM(2)
  ) dut (
    .iCLK(clk), .iRESETn(rst_n), .iDATA(i_data), .iDV(i_dv), .iSTART(i_start),
    .oDATA(o_data), .oDV(o_dv), .oSTART(o_start), .oFRAME_ERR(o_err),
    .oBUSY(o_busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic dv, input logic st, input logic [23:0] d);
    @(posedge clk);
    #1;
    i_dv = dv;
    i_start = st;
    i_data = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 24'h0);
  endtask

  task automatic send_pixel(input int x, input int y, input logic st, input logic [7:0] tag,
                            input bit expect_err, input bit special);
    logic [23:0] d;
    logic [14:0] e;
    bit kept;
    d    = {tag, 8'(y << 3), 8'(x << 3)};
    e    = {tag[7:3], 5'(y), 5'(x)};
    kept = (x == 2 || x == 4) && (y == 1 || y == 3);
    if (special && x == 2 && y == 1) begin
      d = 24'hFF8407;
      e = SPECIAL_EXP;
    end
    drive(1'b1, st, d);
    if (kept) begin
      exp_q.push_back({(x == 2 && y == 1), e});
      exp_cyc_q.push_back(cyc + 2);
    end
    if (expect_err) err_cyc_q.push_back(cyc + 1);
  endtask

  task automatic send_frame(input logic [7:0] tag, input int npix, input bit gap,
                            input bit err_first, input bit special);
    for (int i = 0; i < npix; i++) begin
      send_pixel(i % 8, i / 8, (i == 0), tag, err_first && (i == 0), special);
      if (gap) drive(1'b0, 1'b1, 24'hABCDEF);
    end
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_dv"}, o_dv, 0);
    chk({name, "_start"}, o_start, 0);
    chk({name, "_err"}, o_err, 0);
    chk({name, "_busy"}, o_busy, 0);
    chk({name, "_data"}, o_data, 0);
    chk({name, "_state"}, dbg_state, 0);
  endtask

  // Monitor: every output beat and error pulse must match the head of its queue.
  always @(negedge clk) begin
    if (o_dv) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_dv: got data %0h start %0b, none expected (cycle %0d)", o_data, o_start, cyc);
      end else begin
        logic [15:0] e;
        int ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        if ({o_start, o_data} !== e || cyc != ec) begin
          errors++;
          $display("FAIL out_beat: got start %0b data %0h at cycle %0d, expected start %0b data %0h at cycle %0d",
                   o_start, o_data, cyc, e[15], e[14:0], ec);
        end
      end
    end else if (o_start) begin
      checks++;
      errors++;
      $display("FAIL start_without_dv: oSTART high with oDV low (cycle %0d)", cyc);
    end
    if (o_err) begin
      checks++;
      if (err_cyc_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_frame_err: pulse at cycle %0d, none expected", cyc);
      end else begin
        int ec;
        ec = err_cyc_q.pop_front();
        if (cyc != ec) begin
          errors++;
          $display("FAIL frame_err_cycle: got cycle %0d expected %0d", cyc, ec);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("reset");
    rst_n = 1'b1;
    idle(2);

    // Pixels before any start are discarded silently.
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 24'(32'h00112233 + i));
    idle(2);

    // Nominal frame, continuous iDV.
    send_frame(8'h10, 32, 1'b0, 1'b0, 1'b0);
    idle(4);
    chk("done_busy", o_busy, 0);
    chk("done_state", dbg_state, 2);

    // Same frame with a gap after every pixel (start held high during gaps, no dv).
    send_frame(8'h20, 32, 1'b1, 1'b0, 1'b0);
    idle(4);

    // Short frame: restart after 20 pixels.
    send_frame(8'h30, 20, 1'b0, 1'b0, 1'b0);
    chk("short_busy_mid", o_busy, 1);
    send_frame(8'h38, 32, 1'b0, 1'b1, 1'b0);
    idle(4);

    // Long frame: three extra beats, one error only.
    send_frame(8'h40, 32, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 24'h123456);
    err_cyc_q.push_back(cyc + 1);
    drive(1'b1, 1'b0, 24'h234567);
    drive(1'b1, 1'b0, 24'h345678);
    idle(2);
    send_frame(8'h48, 32, 1'b0, 1'b0, 1'b0);
    idle(4);

    // Packing of an extreme pixel at the window origin.
    send_frame(8'h50, 32, 1'b0, 1'b0, 1'b1);
    idle(4);

    // Mid-frame reset with a kept pixel inside the pipeline.
    for (int i = 0; i <= 10; i++)
      drive(1'b1, (i == 0), {8'h60, 8'((i / 8) << 3), 8'((i % 8) << 3)});
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    i_dv = 1'b0;
    i_start = 1'b0;
    #1;
    chk_quiet("mid_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 24'(32'h00700000 + i));
    idle(3);
    chk("post_reset_busy", o_busy, 0);
    send_frame(8'h68, 32, 1'b0, 1'b0, 1'b0);
    idle(6);

    chk("exp_q_empty", exp_q.size(), 0);
    chk("err_q_empty", err_cyc_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
